// File: rtl/fsm_1_pkg.sv
// fsm_1 shared types: state encoding, address map, response codes.
// Timeout limit is used only when FSM_1_EMPTY_TIMEOUT_EN is defined.
package fsm_1_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_AR     = 4'b0010,
    S_WAIT   = 4'b0100,
    S_RVALID = 4'b1000
  } state_e;

  localparam logic [7:0] ADDR_VARINT = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_RAW    = 8'hF0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned TIMEOUT_LIMIT = 256;
  localparam int unsigned TO_W          = 8;

  typedef enum logic [1:0] {
    T_VARINT,
    T_RAW,
    T_STATUS,
    T_UNMAP
  } target_e;

  function automatic target_e decode(
    input logic [7:0] a
  );
    target_e t;
    t = T_UNMAP;
    if (a == ADDR_VARINT) t = T_VARINT;
    if (a == ADDR_RAW)    t = T_RAW;
    if (a == ADDR_STATUS) t = T_STATUS;
    return t;
  endfunction

endpackage

// File: rtl/fsm_1_timeout.sv
// Empty-FIFO wait timer for fsm_1 (FSM_1_EMPTY_TIMEOUT_EN builds only).
// Counts consecutive FIFO_WAIT cycles; clears whenever the FSM is elsewhere.
module fsm_1_timeout
  import fsm_1_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i &&
    (cnt_q == TO_W'(TIMEOUT_LIMIT - 1));

endmodule

// File: rtl/fsm_1.sv
// AXI4 read slave draining a varint FIFO and a raw-data FIFO.
// Optional empty-FIFO timeout: define FSM_1_EMPTY_TIMEOUT_EN.
module fsm_1
  import fsm_1_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  axs_s0_arid,
  input  logic [31:0] axs_s0_araddr,
  input  logic [7:0]  axs_s0_arlen,
  input  logic [2:0]  axs_s0_arsize,
  input  logic [1:0]  axs_s0_arburst,
  input  logic        axs_s0_arvalid,
  output logic        axs_s0_arready,
  output logic [31:0] axs_s0_rdata,
  output logic [3:0]  axs_s0_rid,
  output logic [1:0]  axs_s0_rresp,
  output logic        axs_s0_rlast,
  output logic        axs_s0_rvalid,
  input  logic        axs_s0_rready,
  input  logic        varint_out_fifo_empty,
  input  logic [31:0] varint_out_fifo_data,
  output logic        varint_out_fifo_pop,
  input  logic        raw_data_out_fifo_empty,
  input  logic [31:0] raw_data_out_fifo_data,
  output logic        raw_data_out_fifo_pop,
  output logic [9:0]  index
);

  state_e      state_q, state_d;
  logic [3:0]  arid_q, arid_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [9:0]  index_q, index_d;
  target_e     tgt;
  logic        is_last;

  // Burst type and size are irrelevant: every beat hits the same FIFO.
  logic unused_ok;
  assign unused_ok = ^{axs_s0_arsize, axs_s0_arburst,
                       axs_s0_araddr[31:8]};

`ifdef FSM_1_EMPTY_TIMEOUT_EN
  logic to_exp;

  fsm_1_timeout u_timeout (
    .clk_i     (clk),
    .rst_ni    (reset),
    .run_i     (state_q == S_WAIT),
    .expired_o (to_exp)
  );
`endif

  assign tgt     = decode(addr_q);
  assign is_last = (beat_q == len_q);

  always_comb begin
    state_d             = state_q;
    arid_d              = arid_q;
    addr_d              = addr_q;
    len_d               = len_q;
    beat_d              = beat_q;
    rdata_d             = rdata_q;
    rresp_d             = rresp_q;
    index_d             = index_q;
    axs_s0_arready      = 1'b0;
    axs_s0_rvalid       = 1'b0;
    axs_s0_rlast        = 1'b0;
    varint_out_fifo_pop = 1'b0;
    raw_data_out_fifo_pop = 1'b0;

    unique case (1'b1)
      (state_q == S_IDLE): begin
        state_d = S_AR;
      end

      (state_q == S_AR): begin
        axs_s0_arready = 1'b1;
        if (axs_s0_arvalid) begin
          arid_d  = axs_s0_arid;
          addr_d  = axs_s0_araddr[7:0];
          len_d   = axs_s0_arlen;
          beat_d  = '0;
          state_d = S_WAIT;
        end
      end

      (state_q == S_WAIT): begin
        unique case (tgt)
          T_VARINT: begin
            if (!varint_out_fifo_empty) begin
              varint_out_fifo_pop = 1'b1;
              rdata_d = varint_out_fifo_data;
              rresp_d = RESP_OKAY;
              index_d = index_q + 10'd1;
              state_d = S_RVALID;
            end
`ifdef FSM_1_EMPTY_TIMEOUT_EN
            else if (to_exp) begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
              state_d = S_RVALID;
            end
`endif
          end
          T_RAW: begin
            if (!raw_data_out_fifo_empty) begin
              raw_data_out_fifo_pop = 1'b1;
              rdata_d = raw_data_out_fifo_data;
              rresp_d = RESP_OKAY;
              index_d = index_q + 10'd1;
              state_d = S_RVALID;
            end
`ifdef FSM_1_EMPTY_TIMEOUT_EN
            else if (to_exp) begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
              state_d = S_RVALID;
            end
`endif
          end
          T_STATUS: begin
            rdata_d = {30'b0, raw_data_out_fifo_empty,
                       varint_out_fifo_empty};
            rresp_d = RESP_OKAY;
            state_d = S_RVALID;
          end
          default: begin
            rdata_d = '0;
            rresp_d = RESP_DECERR;
            state_d = S_RVALID;
          end
        endcase
      end

      (state_q == S_RVALID): begin
        axs_s0_rvalid = 1'b1;
        axs_s0_rlast  = is_last;
        if (axs_s0_rready) begin
          if (is_last) begin
            state_d = S_AR;
          end else begin
            beat_d  = beat_q + 8'd1;
            state_d = S_WAIT;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      arid_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      arid_q  <= arid_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      index_q <= index_d;
    end
  end

  assign axs_s0_rdata = rdata_q;
  assign axs_s0_rid   = arid_q;
  assign axs_s0_rresp = rresp_q;
  assign index        = index_q;

endmodule

// File: tb/tb_fsm_1.sv
// Directed self-checking bench for fsm_1.
// Define FSM_1_EMPTY_TIMEOUT_EN to also exercise the timeout path.
module tb_fsm_1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        v_empty, r_empty;
  logic [31:0] v_data, r_data;
  logic        v_pop, r_pop;
  logic [9:0]  index;

  logic [31:0] vq[$];
  logic [31:0] rq[$];
  int          pops_v = 0;
  int          pops_r = 0;
  int          bad_pop = 0;
  int          nvec = 0;
  int          nmis = 0;

  always #5 clk = ~clk;

  assign v_empty = (vq.size() == 0);
  assign r_empty = (rq.size() == 0);
  assign v_data  = v_empty ? 32'h0 : vq[0];
  assign r_data  = r_empty ? 32'h0 : rq[0];

  fsm_1 dut (
    .clk                     (clk),
    .reset                   (reset),
    .axs_s0_arid             (arid),
    .axs_s0_araddr           (araddr),
    .axs_s0_arlen            (arlen),
    .axs_s0_arsize           (arsize),
    .axs_s0_arburst          (arburst),
    .axs_s0_arvalid          (arvalid),
    .axs_s0_arready          (arready),
    .axs_s0_rdata            (rdata),
    .axs_s0_rid              (rid),
    .axs_s0_rresp            (rresp),
    .axs_s0_rlast            (rlast),
    .axs_s0_rvalid           (rvalid),
    .axs_s0_rready           (rready),
    .varint_out_fifo_empty   (v_empty),
    .varint_out_fifo_data    (v_data),
    .varint_out_fifo_pop     (v_pop),
    .raw_data_out_fifo_empty (r_empty),
    .raw_data_out_fifo_data  (r_data),
    .raw_data_out_fifo_pop   (r_pop),
    .index                   (index)
  );

  always @(posedge clk) begin
    if (v_pop && r_pop) bad_pop++;
    if (v_pop) begin
      pops_v++;
      if (v_empty) bad_pop++;
      else void'(vq.pop_front());
    end
    if (r_pop) begin
      pops_r++;
      if (r_empty) bad_pop++;
      else void'(rq.pop_front());
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ar_req(input logic [3:0] id,
                        input logic [7:0] a,
                        input logic [7:0] len);
    int n;
    n = 0;
    @(negedge clk);
    arid    = id;
    araddr  = {24'h5A5A5A, a};
    arlen   = len;
    arsize  = 3'd2;
    arburst = 2'b01;
    arvalid = 1'b1;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ar_accept", {31'b0, arready}, 32'd1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic get_beat(output logic [31:0] d,
                          output logic [1:0] resp,
                          output logic last,
                          output logic [3:0] id,
                          output int waits);
    waits = 0;
    @(negedge clk);
    while (!rvalid && waits < 400) begin
      waits++;
      @(negedge clk);
    end
    d    = rdata;
    resp = rresp;
    last = rlast;
    id   = rid;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d0;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    int          w, bad, rem, n, pv;
    logic [31:0] exp_raw [4];
    exp_raw[0] = 32'h11111111;
    exp_raw[1] = 32'h22222222;
    exp_raw[2] = 32'h33333333;
    exp_raw[3] = 32'h44444444;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_index", {22'b0, index}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_arready", {31'b0, arready}, 32'd0);
    @(negedge clk);
    check("ar_arready", {31'b0, arready}, 32'd1);

    // Single varint read
    vq.push_back(32'hDEADBEEF);
    ar_req(4'h3, 8'h00, 8'd0);
    check("t1_pop", {31'b0, v_pop}, 32'd1);
    get_beat(d, resp, last, id, w);
    check("t1_latency", w, 1);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", {30'b0, resp}, 32'd0);
    check("t1_rlast", {31'b0, last}, 32'd1);
    check("t1_rid", {28'b0, id}, 32'h3);
    check("t1_index", {22'b0, index}, 32'd1);
    check("t1_pops", pops_v, 1);

    // Raw burst with a stall
    rq.push_back(exp_raw[0]);
    rq.push_back(exp_raw[1]);
    ar_req(4'hA, 8'hF0, 8'd3);
    for (int i = 0; i < 2; i++) begin
      get_beat(d, resp, last, id, w);
      check("t2_rdata", d, exp_raw[i]);
      check("t2_rlast", {31'b0, last}, 32'd0);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rvalid) bad++;
    end
    check("t2_stall_rvalid", bad, 0);
    rq.push_back(exp_raw[2]);
    rq.push_back(exp_raw[3]);
    for (int i = 2; i < 4; i++) begin
      get_beat(d, resp, last, id, w);
      check("t2_rdata", d, exp_raw[i]);
      check("t2_rlast", {31'b0, last}, (i == 3) ? 32'd1 : 32'd0);
      check("t2_rid", {28'b0, id}, 32'hA);
    end
    check("t2_pops", pops_r, 4);
    check("t2_index", {22'b0, index}, 32'd5);

    // Backpressure
    rready = 1'b0;
    vq.push_back(32'h12345678);
    ar_req(4'h1, 8'h00, 8'd0);
    w = 0;
    @(negedge clk);
    while (!rvalid && w < 50) begin
      w++;
      @(negedge clk);
    end
    d0 = rdata;
    check("t3_rdata", d0, 32'h12345678);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!rvalid || rdata !== d0) bad++;
    end
    check("t3_stable", bad, 0);
    check("t3_pops", pops_v, 2);
    rready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_done", {31'b0, rvalid}, 32'd0);
    check("t3_index", {22'b0, index}, 32'd6);

    // Status read: varint empty, raw holds one word
    rq.push_back(32'h000000AA);
    ar_req(4'h2, 8'h08, 8'd0);
    get_beat(d, resp, last, id, w);
    check("t4_rdata", d, 32'h1);
    check("t4_rresp", {30'b0, resp}, 32'd0);
    check("t4_nopop", rq.size(), 1);

    // Unmapped address, two beats
    ar_req(4'h7, 8'h44, 8'd1);
    for (int i = 0; i < 2; i++) begin
      get_beat(d, resp, last, id, w);
      check("t5_rdata", d, 32'h0);
      check("t5_rresp", {30'b0, resp}, 32'h3);
      check("t5_rlast", {31'b0, last}, (i == 1) ? 32'd1 : 32'd0);
    end
    check("t5_pops", pops_v + pops_r, 6);

    // index wrap: 1018 more pops reach 1024
    rem = 1018;
    bad = 0;
    while (rem > 0) begin
      n = (rem > 256) ? 256 : rem;
      for (int k = 0; k < n; k++) vq.push_back(32'h1000 + k);
      ar_req(4'h0, 8'h00, 8'(n - 1));
      for (int k = 0; k < n; k++) begin
        get_beat(d, resp, last, id, w);
        if (d !== 32'h1000 + k) bad++;
      end
      rem -= n;
    end
    check("t6_data", bad, 0);
    check("t6_index_wrap", {22'b0, index}, 32'd0);

`ifdef FSM_1_EMPTY_TIMEOUT_EN
    ar_req(4'h6, 8'h00, 8'd0);
    get_beat(d, resp, last, id, w);
    check("to_wait", w, 256);
    check("to_rresp", {30'b0, resp}, 32'h2);
    check("to_rdata", d, 32'h0);
    check("to_rlast", {31'b0, last}, 32'd1);
`endif

    vq.push_back(32'hCAFE0001);
    ar_req(4'h5, 8'h00, 8'd0);
    get_beat(d, resp, last, id, w);
    check("t7_rdata", d, 32'hCAFE0001);
    check("t7_index", {22'b0, index}, 32'd1);

    // Reset while parked in FIFO_WAIT
    ar_req(4'h6, 8'h00, 8'd0);
`ifdef FSM_1_EMPTY_TIMEOUT_EN
    repeat (3) @(negedge clk);
`else
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (rvalid) bad++;
    end
    check("nto_stall", bad, 0);
`endif
    pv = pops_v;
    reset = 1'b0;
    #1;
    check("rr_arready", {31'b0, arready}, 32'd0);
    check("rr_rvalid", {31'b0, rvalid}, 32'd0);
    check("rr_rdata", rdata, 32'd0);
    check("rr_rid", {28'b0, rid}, 32'd0);
    check("rr_index", {22'b0, index}, 32'd0);
    check("rr_pop", {31'b0, v_pop}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rr_idle", {31'b0, arready}, 32'd0);
    @(negedge clk);
    check("rr_ar", {31'b0, arready}, 32'd1);
    check("rr_nopop", pops_v, pv);
    check("pop_rules", bad_pop, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fsm_1.md
FSM_1 -- requirements
Module: fsm_1

Interface
REQ-001 SHALL provide: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset; asserting it (low) resets the block immediately.
REQ-003 SHALL provide AXI4 read-address inputs: axs_s0_arid in 4, axs_s0_araddr in 32, axs_s0_arlen in 8, axs_s0_arsize in 3, axs_s0_arburst in 2, axs_s0_arvalid in 1.
REQ-004 SHALL provide: axs_s0_arready  out  1  address accept.
REQ-005 SHALL provide AXI4 read-data outputs: axs_s0_rdata out 32, axs_s0_rid out 4, axs_s0_rresp out 2, axs_s0_rlast out 1, axs_s0_rvalid out 1.
REQ-006 SHALL provide: axs_s0_rready  in  1  master accepts beat.
REQ-007 SHALL provide varint output FIFO port: varint_out_fifo_empty in 1, varint_out_fifo_data in 32 (show-ahead), varint_out_fifo_pop out 1.
REQ-008 SHALL provide raw-data output FIFO port: raw_data_out_fifo_empty in 1, raw_data_out_fifo_data in 32 (show-ahead), raw_data_out_fifo_pop out 1.
REQ-009 SHALL provide: index  out  10  count of words popped, both FIFOs combined.

Function
REQ-010 SHALL decode araddr[7:0]: 0x00 varint data, 0xF0 raw data, 0x08 status; any other value is unmapped.
REQ-011 SHALL implement states IDLE, AR_READY, FIFO_WAIT, R_VALID.
REQ-012 IDLE SHALL last one cycle after reset release, then go to AR_READY.
REQ-013 AR_READY SHALL drive arready=1.
REQ-014 On arvalid&&arready, SHALL latch arid, araddr[7:0], and arlen, clear the beat counter, and go to FIFO_WAIT.
REQ-015 In FIFO_WAIT, for a data address with its FIFO non-empty, SHALL latch rdata from that FIFO, pulse the matching pop for exactly one cycle, increment index, and go to R_VALID.
REQ-016 In FIFO_WAIT, for a data address with its FIFO empty, SHALL remain in FIFO_WAIT with rvalid=0 and no pop.
REQ-017 Status reads SHALL return rdata={30'b0, raw_data_out_fifo_empty, varint_out_fifo_empty}, rresp=OKAY, no pop.
REQ-018 Unmapped reads SHALL return rdata=0, rresp=DECERR (2'b11), no pop; the full burst SHALL still be delivered.
REQ-019 R_VALID SHALL hold rvalid=1 and rid=latched arid, with rdata and rresp stable until rready.
REQ-020 In R_VALID, rlast SHALL be 1 iff beat counter == latched arlen.
REQ-021 On rvalid&&rready: if last beat, SHALL go to AR_READY; otherwise SHALL increment the beat counter and go to FIFO_WAIT.
REQ-022 Latency: AR handshake at cycle N with data available SHALL give rvalid=1 at cycle N+2.
REQ-023 index SHALL wrap from 1023 to 0.
REQ-024 arsize and arburst SHALL be accepted and ignored; every beat SHALL target the latched address (FIFO semantics).
REQ-025 At most one pop SHALL be asserted per cycle, and a pop SHALL never be asserted while its FIFO reports empty.

Reset
REQ-026 While reset is low, SHALL force state=IDLE, arready=0, rvalid=0, rlast=0, rdata=0, rid=0, rresp=0, both pops=0, index=0, beat counter=0.
REQ-027 Reset mid-burst SHALL abandon the burst with no further pops; the already-popped word is lost.

Configuration
REQ-028 Macro FSM_1_EMPTY_TIMEOUT_EN SHALL be supported.
REQ-029 When FSM_1_EMPTY_TIMEOUT_EN is defined, FIFO_WAIT lasting 256 consecutive cycles SHALL deliver the beat with rdata=0 and rresp=SLVERR (2'b10), without a pop.
REQ-030 When FSM_1_EMPTY_TIMEOUT_EN is defined, the timeout counter SHALL restart on each FIFO_WAIT entry.
REQ-031 When FSM_1_EMPTY_TIMEOUT_EN is undefined, FIFO_WAIT SHALL stall indefinitely and no timeout logic SHALL exist.

Structure
REQ-032 Package fsm_1_pkg SHALL hold the state encoding (one-hot, 4 bits), address constants (0x00, 0x08, 0xF0), response codes (OKAY, SLVERR, DECERR), and the timeout limit 256.
REQ-033 The timeout counter SHALL be sub-module fsm_1_timeout, instantiated only under FSM_1_EMPTY_TIMEOUT_EN; all other logic SHALL be flat.

Verification
REQ-034 Single varint read: araddr=0x00, arlen=0, FIFO holds 0xDEADBEEF, rready=1 -> rdata=0xDEADBEEF, rresp=0, rlast=1, one pop, index=1.
REQ-035 Raw burst with stall: araddr=0xF0, arlen=3, FIFO holds 2 words then refills after 10 cycles -> 4 beats in order, rvalid low during the stall, rlast only on beat 4, 4 pops.
REQ-036 Backpressure and status: rready held low for 5 cycles -> rdata stable, no extra pop; status read 0x08 with varint empty and raw non-empty -> rdata=0x1.
REQ-037 Unmapped read: araddr=0x44, arlen=1 -> 2 beats, rdata=0, rresp=2'b11, no pops.
REQ-038 Wrap and reset: 1024 pops -> index=0; reset asserted in FIFO_WAIT -> all outputs zero asynchronously, then IDLE then AR_READY.
REQ-039 With FSM_1_EMPTY_TIMEOUT_EN defined, read 0x00 with FIFO empty -> after 256 cycles, rvalid=1, rresp=2'b10, rdata=0.
